// File: rtl/tlb_unit_pkg.sv
// tlb_unit_pkg: shared TLB entry layout, constants and the address translation helper.
package tlb_unit_pkg;
  localparam logic [2:0] CACHE_UNCACHED = 3'd2;
  localparam logic [1:0] KSEG01_TOP = 2'b10;
  typedef struct packed {
    logic [23:0] pfn;
    logic [2:0] c;
    logic d;
    logic v;
  } tlb_lo_t;
  typedef struct packed {
    logic [18:0] vpn2;
    logic g;
    logic [7:0] asid;
    tlb_lo_t lo0;
    tlb_lo_t lo1;
  } tlb_entry_t;
  typedef struct packed {
    logic [31:0] paddr;
    logic uncached;
    logic refill;
    logic invalid;
  } tlb_resp_t;
  function automatic logic is_mod(input logic [31:0] va, input logic hit, input tlb_lo_t lo, input logic store);
    return va[31:30] != KSEG01_TOP && hit && lo.v && store && !lo.d;
  endfunction
  // Unmapped kseg0/kseg1 bypass the TLB; mapped faults force paddr to zero.
  function automatic tlb_resp_t translate(input logic [31:0] va, input logic hit, input tlb_lo_t lo,
                                          input logic k0_unc, input logic store);
    tlb_resp_t r;
    r = '0;
    if (va[31:30] == KSEG01_TOP) begin
      r.paddr = {3'b0, va[28:0]};
      r.uncached = va[29] | k0_unc;
    end else begin
      r.refill = !hit;
      r.invalid = hit && !lo.v;
      r.uncached = lo.c == CACHE_UNCACHED;
      r.paddr = (r.refill || r.invalid || is_mod(va, hit, lo, store)) ? 32'h0 : {lo.pfn[19:0], va[11:0]};
    end
    return r;
  endfunction
endpackage

// File: rtl/tlb_lookup.sv
// tlb_lookup: fully associative match with lowest-index priority and even/odd page select.
module tlb_lookup
  import tlb_unit_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W = 4
) (
  input  tlb_entry_t       entries [ENTRIES],
  input  logic [18:0]      vpn2,
  input  logic [7:0]       asid,
  input  logic             odd,
  output logic             hit,
  output logic [IDX_W-1:0] index,
  output tlb_lo_t          lo
);
  always_comb begin
    hit = 1'b0;
    index = '0;
    lo = '0;
    for (int k = ENTRIES - 1; k >= 0; k--)
      if (entries[k].vpn2 == vpn2 && (entries[k].g || entries[k].asid == asid)) begin
        hit = 1'b1;
        index = k[IDX_W-1:0];
        lo = odd ? entries[k].lo1 : entries[k].lo0;
      end
  end
endmodule

// File: rtl/tlb_unit.sv
// tlb_unit: 16-entry joint TLB with registered I/D translation, TLBP probe and TLBR read.
module tlb_unit
  import tlb_unit_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tlbwi,
  input  logic             tlbwr,
  input  logic [IDX_W-1:0] cp0_index,
  input  logic [IDX_W-1:0] cp0_random,
  input  logic [85:0]      cp0_tlb_conf_out,
  output logic [85:0]      cp0_tlb_conf_in,
  output logic             miss_probe,
  output logic [IDX_W-1:0] matched_index_probe,
  input  logic [7:0]       curr_ASID,
  input  logic             cp0_kseg0_uncached,
  input  logic             i_valid,
  input  logic             d_valid,
  input  logic [31:0]      i_vaddr,
  input  logic [31:0]      d_vaddr,
  input  logic             i_stall,
  input  logic             d_stall,
  input  logic             d_is_store,
  output logic             i_resp_valid,
  output logic             d_resp_valid,
  output logic [31:0]      i_paddr,
  output logic [31:0]      d_paddr,
  output logic             i_uncached,
  output logic             d_uncached,
  output logic             i_refill,
  output logic             d_refill,
  output logic             i_invalid,
  output logic             d_invalid,
  output logic             d_modified
);
  tlb_entry_t entries [ENTRIES];
  tlb_entry_t key;
  tlb_lo_t i_lo, d_lo;
  logic i_hit, d_hit, p_hit;
  logic [IDX_W-1:0] i_idx, d_idx;
  tlb_resp_t i_t, d_t;
  assign key = cp0_tlb_conf_out;
  assign cp0_tlb_conf_in = entries[cp0_index];
  assign miss_probe = !p_hit;
  tlb_lookup #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_i (
    .entries(entries), .vpn2(i_vaddr[31:13]), .asid(curr_ASID), .odd(i_vaddr[12]),
    .hit(i_hit), .index(i_idx), .lo(i_lo));
  tlb_lookup #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_d (
    .entries(entries), .vpn2(d_vaddr[31:13]), .asid(curr_ASID), .odd(d_vaddr[12]),
    .hit(d_hit), .index(d_idx), .lo(d_lo));
  tlb_lookup #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_p (
    .entries(entries), .vpn2(key.vpn2), .asid(key.asid), .odd(1'b0),
    .hit(p_hit), .index(matched_index_probe), .lo());
  assign i_t = translate(i_vaddr, i_hit, i_lo, cp0_kseg0_uncached, 1'b0);
  assign d_t = translate(d_vaddr, d_hit, d_lo, cp0_kseg0_uncached, d_is_store);
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int k = 0; k < ENTRIES; k++) entries[k] <= '0;
    else if (tlbwi || tlbwr) entries[tlbwi ? cp0_index : cp0_random] <= key;
  always_ff @(posedge clk or posedge rst)
    if (rst) {i_resp_valid, i_paddr, i_uncached, i_refill, i_invalid} <= '0;
    else if (!i_stall) {i_resp_valid, i_paddr, i_uncached, i_refill, i_invalid} <= {i_valid, i_t};
  always_ff @(posedge clk or posedge rst)
    if (rst) {d_resp_valid, d_paddr, d_uncached, d_refill, d_invalid, d_modified} <= '0;
    else if (!d_stall)
      {d_resp_valid, d_paddr, d_uncached, d_refill, d_invalid, d_modified} <=
        {d_valid, d_t, is_mod(d_vaddr, d_hit, d_lo, d_is_store)};
  logic unused;
  assign unused = ^{i_idx, d_idx};
endmodule
